// File: rtl/saw_tx_controller_if.sv
// Packet-in / frame-out / ACK-in bundle of the stop-and-wait sender.
// The controller takes master; the network layer and channel side take slave.
interface saw_tx_controller_if #(
    parameter int DATA_W  = 8,
    parameter int RETRY_W = 2
) ();
    logic               pkt_valid;
    logic [DATA_W-1:0]  pkt_data;
    logic               pkt_ready;
    logic               frm_valid;
    logic [DATA_W-1:0]  frm_data;
    logic               frm_seq;
    logic               frm_ready;
    logic               ack_valid;
    logic               ack_seq;
    logic               ack_err;
    logic               fail_clr;
    logic               tx_ok;
    logic               fail;
    logic               busy;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  pkt_valid, pkt_data, frm_ready, ack_valid, ack_seq, ack_err, fail_clr,
        output pkt_ready, frm_valid, frm_data, frm_seq, tx_ok, fail, busy, retry_cnt
    );

    modport slave (
        output pkt_valid, pkt_data, frm_ready, ack_valid, ack_seq, ack_err, fail_clr,
        input  pkt_ready, frm_valid, frm_data, frm_seq, tx_ok, fail, busy, retry_cnt
    );
endinterface

// File: rtl/saw_tx_controller.sv
// Stop-and-wait ARQ sender: one frame in flight, 1-bit sequence, timed retransmit, retry limit.
// Accept->frame 1 cycle, ACK->ready 1 cycle; frame held stable while frm_ready is low.
module saw_tx_controller #(
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 10,
    parameter int TIMER_W   = 8,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_W   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    saw_tx_controller_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FAIL} state_t;

    state_t             state, state_n;
    logic               seq, seq_n;
    logic [DATA_W-1:0]  copy, copy_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [RETRY_W-1:0] retry, retry_n;
    logic               tx_ok_r, tx_ok_n;
    logic               good_ack;
    logic               timeout;

    assign good_ack = bus.ack_valid & ~bus.ack_err & (bus.ack_seq == seq);
    assign timeout  = (timer == TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            seq     <= 1'b0;
            copy    <= '0;
            timer   <= '0;
            retry   <= '0;
            tx_ok_r <= 1'b0;
        end else begin
            state   <= state_n;
            seq     <= seq_n;
            copy    <= copy_n;
            timer   <= timer_n;
            retry   <= retry_n;
            tx_ok_r <= tx_ok_n;
        end
    end

    always_comb begin
        state_n = state;
        seq_n   = seq;
        copy_n  = copy;
        timer_n = timer;
        retry_n = retry;
        tx_ok_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.pkt_valid) begin
                    copy_n  = bus.pkt_data;
                    retry_n = '0;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.frm_ready) begin
                    timer_n = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_n = timer + TIMER_W'(1);
                // A good ACK on the timeout cycle still wins over the retransmit.
                if (good_ack) begin
                    seq_n   = ~seq;
                    tx_ok_n = 1'b1;
                    timer_n = '0;
                    state_n = S_IDLE;
                end else if (timeout) begin
                    timer_n = '0;
                    if (retry < RETRY_W'(MAX_RETRY)) begin
                        retry_n = retry + RETRY_W'(1);
                        state_n = S_SEND;
                    end else begin
                        state_n = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                if (bus.fail_clr) begin
                    retry_n = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.pkt_ready = (state == S_IDLE);
    assign bus.frm_valid = (state == S_SEND);
    assign bus.frm_data  = copy;
    assign bus.frm_seq   = seq;
    assign bus.tx_ok     = tx_ok_r;
    assign bus.fail      = (state == S_FAIL);
    assign bus.busy      = (state != S_IDLE);
    assign bus.retry_cnt = retry;
endmodule

// File: tb/tb_saw_tx_controller.sv
// Bench for the stop-and-wait sender: transaction table plus directed retry/fail/reset sequences.
// Frames seen on the channel are checked against a queue of expected frames.
module tb_saw_tx_controller;
    localparam int DATA_W    = 8;
    localparam int TIMEOUT   = 10;
    localparam int MAX_RETRY = 3;
    localparam int RETRY_W   = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    saw_tx_controller_if #(.DATA_W(DATA_W), .RETRY_W(RETRY_W)) bus ();

    saw_tx_controller #(
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TIMER_W(8),
        .MAX_RETRY(MAX_RETRY), .RETRY_W(RETRY_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [DATA_W-1:0]  data;
        logic               seq;
        logic [RETRY_W-1:0] retry;
    } frame_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                delay;
        logic              seq;
    } vec_t;

    frame_t exp_q[$];
    vec_t   tbl[5];
    int     tests = 0;
    int     fails = 0;
    logic   mseq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Frame handshakes are observed mid-cycle, when inputs and outputs are both settled.
    always @(negedge clk) begin : mon
        frame_t f;
        if (rstn && bus.frm_valid && bus.frm_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got data %0h seq %0d, expected no frame",
                         bus.frm_data, bus.frm_seq);
            end else begin
                f = exp_q.pop_front();
                chk("frm_data", 32'(bus.frm_data), 32'(f.data));
                chk("frm_seq", 32'(bus.frm_seq), 32'(f.seq));
                chk("frm_retry", 32'(bus.retry_cnt), 32'(f.retry));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DATA_W-1:0] d);
        chk("pkt_ready_idle", 32'(bus.pkt_ready), 32'd1);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = d;
        tick();
        bus.pkt_valid = 1'b0;
        chk("accept_latency", 32'(bus.frm_valid), 32'd1);
    endtask

    task automatic handshake();
        bus.frm_ready = 1'b1;
        tick();
        bus.frm_ready = 1'b0;
        chk("wait_entered", 32'(bus.frm_valid), 32'd0);
    endtask

    task automatic good_ack(input int d, input logic s);
        repeat (d) tick();
        bus.ack_valid = 1'b1;
        bus.ack_seq   = s;
        bus.ack_err   = 1'b0;
        tick();
        bus.ack_valid = 1'b0;
        chk("tx_ok_pulse", 32'(bus.tx_ok), 32'd1);
        chk("ready_after_ack", 32'(bus.pkt_ready), 32'd1);
        tick();
        chk("tx_ok_single", 32'(bus.tx_ok), 32'd0);
    endtask

    task automatic wait_frm(input int req, input string name);
        int n = 0;
        while (!bus.frm_valid && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(req));
    endtask

    initial begin
        int n;
        tbl[0] = '{8'hA5, 3, 1'b0};
        tbl[1] = '{8'h3C, 0, 1'b1};
        tbl[2] = '{8'hFF, 9, 1'b0};
        tbl[3] = '{8'h00, 5, 1'b1};
        tbl[4] = '{8'h5A, 1, 1'b0};

        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.frm_ready = 1'b0;
        bus.ack_valid = 1'b0;
        bus.ack_seq   = 1'b0;
        bus.ack_err   = 1'b0;
        bus.fail_clr  = 1'b0;
        rstn          = 1'b0;
        repeat (2) tick();
        chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        chk("rst_frm_valid", 32'(bus.frm_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fail", 32'(bus.fail), 32'd0);
        chk("rst_frm_data", 32'(bus.frm_data), 32'd0);
        chk("rst_retry", 32'(bus.retry_cnt), 32'd0);
        chk("rst_tx_ok", 32'(bus.tx_ok), 32'd0);
        rstn = 1'b1;
        tick();
        mseq = 1'b0;

        // Delay 9 lands the ACK on the timeout cycle.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{tbl[i].data, tbl[i].seq, 2'd0});
            offer(tbl[i].data);
            handshake();
            good_ack(tbl[i].delay, tbl[i].seq);
            mseq = ~tbl[i].seq;
        end
        repeat (3) tick();
        chk("no_retx_after_late_ack", 32'(bus.frm_valid), 32'd0);

        // Single timeout then success.
        exp_q.push_back('{8'h77, mseq, 2'd0});
        exp_q.push_back('{8'h77, mseq, 2'd1});
        offer(8'h77);
        handshake();
        wait_frm(TIMEOUT, "timeout_latency");
        chk("retx_retry_cnt", 32'(bus.retry_cnt), 32'd1);
        chk("retx_data", 32'(bus.frm_data), 32'h77);
        handshake();
        good_ack(0, mseq);
        mseq = ~mseq;

        // Corrupted ACK and wrong-sequence ACK must not stop the timer.
        exp_q.push_back('{8'h99, mseq, 2'd0});
        exp_q.push_back('{8'h99, mseq, 2'd1});
        offer(8'h99);
        handshake();
        repeat (2) tick();
        bus.ack_valid = 1'b1;
        bus.ack_err   = 1'b1;
        bus.ack_seq   = mseq;
        tick();
        bus.ack_err   = 1'b0;
        bus.ack_seq   = ~mseq;
        tick();
        bus.ack_valid = 1'b0;
        chk("bad_ack_no_tx_ok", 32'(bus.tx_ok), 32'd0);
        chk("bad_ack_busy", 32'(bus.busy), 32'd1);
        wait_frm(TIMEOUT - 4, "timeout_after_bad_acks");
        handshake();
        good_ack(2, mseq);
        mseq = ~mseq;

        // Retry exhaustion: original plus MAX_RETRY retransmissions, then FAIL.
        for (int r = 0; r <= MAX_RETRY; r++) exp_q.push_back('{8'hC3, mseq, RETRY_W'(r)});
        offer(8'hC3);
        bus.frm_ready = 1'b1;
        n = 0;
        while (!bus.fail && n < 200) begin
            tick();
            n++;
        end
        bus.frm_ready = 1'b0;
        chk("cycles_to_fail", 32'(n), 32'((MAX_RETRY + 1) * (TIMEOUT + 1)));
        chk("fail_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        chk("fail_busy", 32'(bus.busy), 32'd1);
        chk("fail_retry_sat", 32'(bus.retry_cnt), 32'(MAX_RETRY));
        chk("fail_frames_seen", 32'(exp_q.size()), 32'd0);
        bus.ack_valid = 1'b1;
        bus.ack_seq   = mseq;
        tick();
        bus.ack_valid = 1'b0;
        chk("fail_ack_ignored", 32'(bus.tx_ok), 32'd0);
        chk("fail_held", 32'(bus.fail), 32'd1);
        bus.fail_clr = 1'b1;
        tick();
        bus.fail_clr = 1'b0;
        chk("clr_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        chk("clr_retry", 32'(bus.retry_cnt), 32'd0);
        chk("clr_fail", 32'(bus.fail), 32'd0);

        // Channel backpressure in SEND, then reset while waiting; seq is unchanged by FAIL.
        exp_q.push_back('{8'h6E, mseq, 2'd0});
        offer(8'h6E);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_frm_valid", 32'(bus.frm_valid), 32'd1);
            chk("stall_frm_data", 32'(bus.frm_data), 32'h6E);
            chk("stall_frm_seq", 32'(bus.frm_seq), 32'(mseq));
        end
        handshake();
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_frm_valid", 32'(bus.frm_valid), 32'd0);
        chk("mid_rst_tx_ok", 32'(bus.tx_ok), 32'd0);
        chk("mid_rst_seq", 32'(bus.frm_seq), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        mseq = 1'b0;
        exp_q.push_back('{8'h11, mseq, 2'd0});
        offer(8'h11);
        handshake();
        good_ack(1, mseq);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
